hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It sequences the stage-register write enables, bubbles and flushes that the forwarding unit cannot resolve: load-use stalls, multi-cycle multiply occupancy of EX, data-memory wait states and taken-branch flushes. It also keeps saturating stall and flush performance counters. It sits beside the forwarding unit and drives the enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_if.sv | 45 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef logic state_t;

  // FSM state encoding
  localparam state_t StRun = 1'b0;
  localparam state_t StMul = 1'b1;

  // Legal range of the multiply occupancy parameter
  localparam int unsigned MulLatMin = 1;
  localparam int unsigned MulLatMax = 16;

  // Width of the multiply down-counter (holds up to MulLatMax-2)
  localparam int unsigned MulCntW = 4;

  // Bubble encoding the stage registers load when told to: addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface hazard_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [4:0]       IFID_rs1_i;
  logic [4:0]       IFID_rs2_i;
  logic [4:0]       IDEX_rd_i;
  logic             IDEX_MemRead_i;
  logic             EX_mul_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;

  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IDEX_write_o;
  logic             EXMEM_write_o;
  logic             IFID_flush_o;
  logic             IDEX_bubble_o;
  logic             EXMEM_bubble_o;
  logic             MEMWB_bubble_o;
  logic             mul_busy_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Datapath side: supplies hazard sources, consumes enables.
  modport master (
    output IFID_rs1_i, IFID_rs2_i, IDEX_rd_i, IDEX_MemRead_i, EX_mul_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    input  PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o, IFID_flush_o,
           IDEX_bubble_o, EXMEM_bubble_o, MEMWB_bubble_o, mul_busy_o,
           stall_cnt_o, flush_cnt_o
  );

  // Hazard controller side.
  modport slave (
    input  IFID_rs1_i, IFID_rs2_i, IDEX_rd_i, IDEX_MemRead_i, EX_mul_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    output PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o, IFID_flush_o,
           IDEX_bubble_o, EXMEM_bubble_o, MEMWB_bubble_o, mul_busy_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count qualifying cycles, sticking at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles, flushes and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  hazard_if.slave  bus
);

  // A one-cycle multiply never needs to stall EX.
  localparam logic               MulEn   = (MUL_LAT > 1);
  localparam logic [MulCntW-1:0] CntLoad = (MUL_LAT > 1) ? MulCntW'(MUL_LAT - 2) : '0;

  state_t             state_q, state_d;
  logic [MulCntW-1:0] cnt_q, cnt_d;
  logic               mem_freeze, load_use, mul_stall;

  // Hazard detection and multiply sequencing
  always_comb begin
    mem_freeze = bus.mem_req_i & ~bus.mem_ack_i;
    load_use   = bus.IDEX_MemRead_i & (bus.IDEX_rd_i != 5'd0) &
                 ((bus.IDEX_rd_i == bus.IFID_rs1_i) | (bus.IDEX_rd_i == bus.IFID_rs2_i));
    mul_stall  = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (!mem_freeze) begin
      if (state_q == StRun) begin
        if (bus.EX_mul_i && MulEn) begin
          mul_stall = 1'b1;
          state_d   = StMul;
          cnt_d     = CntLoad;
        end
      end else if (cnt_q != '0) begin
        mul_stall = 1'b1;
        cnt_d     = cnt_q - 1'b1;
      end else begin
        // Release cycle: EX result is written, pipeline advances.
        state_d = StRun;
      end
    end
  end

  // FSM state and multiply down-counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prioritised enables; any stall suppresses a taken-branch flush
  always_comb begin
    bus.PC_write_o     = 1'b1;
    bus.IFID_write_o   = 1'b1;
    bus.IDEX_write_o   = 1'b1;
    bus.EXMEM_write_o  = 1'b1;
    bus.IFID_flush_o   = 1'b0;
    bus.IDEX_bubble_o  = 1'b0;
    bus.EXMEM_bubble_o = 1'b0;
    bus.MEMWB_bubble_o = 1'b0;
    bus.mul_busy_o     = 1'b0;
    if (rst_i) begin
      bus.PC_write_o    = 1'b0;
      bus.IFID_write_o  = 1'b0;
      bus.IDEX_write_o  = 1'b0;
      bus.EXMEM_write_o = 1'b0;
    end else if (mem_freeze) begin
      bus.PC_write_o     = 1'b0;
      bus.IFID_write_o   = 1'b0;
      bus.IDEX_write_o   = 1'b0;
      bus.EXMEM_write_o  = 1'b0;
      bus.MEMWB_bubble_o = 1'b1;
    end else if (mul_stall) begin
      bus.PC_write_o     = 1'b0;
      bus.IFID_write_o   = 1'b0;
      bus.IDEX_write_o   = 1'b0;
      bus.EXMEM_bubble_o = 1'b1;
      bus.mul_busy_o     = 1'b1;
    end else if (load_use) begin
      bus.PC_write_o    = 1'b0;
      bus.IFID_write_o  = 1'b0;
      bus.IDEX_bubble_o = 1'b1;
    end else if (bus.branch_taken_i) begin
      bus.IFID_flush_o = 1'b1;
    end
  end

  logic stall_inc;
  assign stall_inc = ~bus.PC_write_o & ~rst_i;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bus.IFID_flush_o),
    .cnt_o (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one MUL_LAT=4 instance and one MUL_LAT=1, CNT_W=4 instance.
module tb_hazard_ctrl;

  // Output pattern order: PC, IFID, IDEX, EXMEM, flush, IDEX_b, EXMEM_b, MEMWB_b, mul_busy
  localparam logic [8:0] ONone  = 9'b111100000;
  localparam logic [8:0] OLu    = 9'b001101000;
  localparam logic [8:0] OMul   = 9'b000100101;
  localparam logic [8:0] OFrz   = 9'b000000010;
  localparam logic [8:0] OFlush = 9'b111110000;
  localparam logic [8:0] OZero  = 9'b000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(32)) bus0 ();
  hazard_if #(.CNT_W(4))  bus1 ();

  hazard_ctrl #(
    .MUL_LAT (4),
    .CNT_W   (32)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  hazard_ctrl #(
    .MUL_LAT (1),
    .CNT_W   (4)
  ) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  assign bus1.IFID_rs1_i     = bus0.IFID_rs1_i;
  assign bus1.IFID_rs2_i     = bus0.IFID_rs2_i;
  assign bus1.IDEX_rd_i      = bus0.IDEX_rd_i;
  assign bus1.IDEX_MemRead_i = bus0.IDEX_MemRead_i;
  assign bus1.EX_mul_i       = bus0.EX_mul_i;
  assign bus1.branch_taken_i = bus0.branch_taken_i;
  assign bus1.mem_req_i      = bus0.mem_req_i;
  assign bus1.mem_ack_i      = bus0.mem_ack_i;

  logic [8:0] o0, o1;
  assign o0 = {bus0.PC_write_o, bus0.IFID_write_o, bus0.IDEX_write_o, bus0.EXMEM_write_o,
               bus0.IFID_flush_o, bus0.IDEX_bubble_o, bus0.EXMEM_bubble_o,
               bus0.MEMWB_bubble_o, bus0.mul_busy_o};
  assign o1 = {bus1.PC_write_o, bus1.IFID_write_o, bus1.IDEX_write_o, bus1.EXMEM_write_o,
               bus1.IFID_flush_o, bus1.IDEX_bubble_o, bus1.EXMEM_bubble_o,
               bus1.MEMWB_bubble_o, bus1.mul_busy_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic memrd, input logic mul, input logic br,
                        input logic req, input logic ack);
    bus0.IFID_rs1_i     = rs1;
    bus0.IFID_rs2_i     = rs2;
    bus0.IDEX_rd_i      = rd;
    bus0.IDEX_MemRead_i = memrd;
    bus0.EX_mul_i       = mul;
    bus0.branch_taken_i = br;
    bus0.mem_req_i      = req;
    bus0.mem_ack_i      = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_outs", 32'(o0), 32'(OZero));
    chk("rst_outs_l1", 32'(o1), 32'(OZero));
    chk("rst_stall_cnt", bus0.stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", bus0.flush_cnt_o, 32'd0);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle", 32'(o0), 32'(ONone));
    tick();

    // Load-use on rs2, then rd=0 is not a hazard
    set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs2", 32'(o0), 32'(OLu));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_after", 32'(o0), 32'(ONone));
    chk("lu_stall_cnt", bus0.stall_cnt_o, 32'd1);
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_rd0", 32'(o0), 32'(ONone));
    tick();
    set_in(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs1", 32'(o0), 32'(OLu));
    chk("lu_rd0_cnt", bus0.stall_cnt_o, 32'd1);
    tick();

    // Branch suppressed by load-use, flushes when re-presented
    set_in(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_lu", 32'(o0), 32'(OLu));
    tick();
    set_in(5'd1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_flush", 32'(o0), 32'(OFlush));
    chk("br_stall_cnt", bus0.stall_cnt_o, 32'd3);
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_flush_cnt", bus0.flush_cnt_o, 32'd1);

    // Multiply held high: 3 stalls, release, then back-to-back restart
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mul_s1", 32'(o0), 32'(OMul));
    chk("mul_l1_none", 32'(o1), 32'(ONone));
    tick();
    chk("mul_s2", 32'(o0), 32'(OMul));
    tick();
    chk("mul_s3", 32'(o0), 32'(OMul));
    tick();
    chk("mul_release", 32'(o0), 32'(ONone));
    tick();
    chk("mul_stall_cnt", bus0.stall_cnt_o, 32'd3);
    chk("mul_restart", 32'(o0), 32'(OMul));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mul2_s2", 32'(o0), 32'(OMul));
    tick();
    chk("mul2_s3", 32'(o0), 32'(OMul));
    tick();
    chk("mul2_release", 32'(o0), 32'(ONone));
    tick();
    chk("mul2_stall_cnt", bus0.stall_cnt_o, 32'd6);
    chk("mul_l1_stall_cnt", 32'(bus1.stall_cnt_o), 32'd0);

    // Memory wait during the second multiply stall cycle
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mw_s1", 32'(o0), 32'(OMul));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mw_frz1", 32'(o0), 32'(OFrz));
    chk("mw_frz1_l1", 32'(o1), 32'(OFrz));
    tick();
    chk("mw_frz2", 32'(o0), 32'(OFrz));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw_s2", 32'(o0), 32'(OMul));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mw_s3_acked", 32'(o0), 32'(OMul));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw_release", 32'(o0), 32'(ONone));
    tick();
    chk("mw_stall_cnt", bus0.stall_cnt_o, 32'd5);

    // Reset in the second multiply stall cycle
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rm_s1", 32'(o0), 32'(OMul));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rm_s2", 32'(o0), 32'(OMul));
    rst = 1'b1;
    #1;
    chk("rm_outs", 32'(o0), 32'(OZero));
    chk("rm_stall_cnt", bus0.stall_cnt_o, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_after", 32'(o0), 32'(ONone));
    tick();
    chk("rm_after2", 32'(o0), 32'(ONone));

    // Saturation of the 4-bit counter under repeated load-use
    for (int i = 0; i < 20; i++) begin
      set_in(5'd0, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 14) chk("sat_15", 32'(bus1.stall_cnt_o), 32'd15);
    end
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", 32'(bus1.stall_cnt_o), 32'd15);
    chk("sat_wide", bus0.stall_cnt_o, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
